// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: load, hold, shift, rotate, plus an
// autonomous N-step burst mode that pulses done on completion.
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             ser_in_lsb,
  input  logic             ser_in_msb,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] dout,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_SHR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_ROR  = 3'd5;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] dout_reg, dout_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       mode_reg, mode_next;
  logic             done_reg, done_next;

  function automatic logic [WIDTH-1:0] apply_step(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] d,
    input logic [WIDTH-1:0] load_val,
    input logic             sl,
    input logic             sm
  );
    logic [WIDTH-1:0] r;
    r = d;
    case (op)
      MODE_HOLD: r = d;
      MODE_LOAD: r = load_val;
      MODE_SHL:  r = {d[WIDTH-2:0], sl};
      MODE_SHR:  r = {sm, d[WIDTH-1:1]};
      MODE_ROL:  r = {d[WIDTH-2:0], d[WIDTH-1]};
      MODE_ROR:  r = {d[0], d[WIDTH-1:1]};
      default:   r = d;
    endcase
    return r;
  endfunction

  // Only the four shift/rotate codes are meaningful as a burst operation.
  function automatic logic is_burst_mode(input logic [2:0] op);
    return (op == MODE_SHL) || (op == MODE_SHR) ||
           (op == MODE_ROL) || (op == MODE_ROR);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      dout_reg  <= '0;
      cnt_reg   <= '0;
      mode_reg  <= MODE_HOLD;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      dout_reg  <= dout_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    dout_next  = dout_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          // start wins over enable; a rejected request still acknowledges with done
          if (is_burst_mode(mode) && (count != '0)) begin
            mode_next  = mode;
            cnt_next   = count;
            state_next = BURST;
          end else begin
            done_next = 1'b1;
          end
        end else if (enable) begin
          dout_next = apply_step(mode, dout_reg, din, ser_in_lsb, ser_in_msb);
        end
      end
      BURST: begin
        // serial inputs are taken live so a burst can stream bits in
        dout_next = apply_step(mode_reg, dout_reg, din, ser_in_lsb, ser_in_msb);
        cnt_next  = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign dout        = dout_reg;
  assign ser_out_msb = dout_reg[WIDTH-1];
  assign ser_out_lsb = dout_reg[0];
  assign busy        = (state_reg == BURST);
  assign done        = done_reg;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed self-checking bench for universal_shift_register (WIDTH=8, CNT_W=4).
module tb_universal_shift_register;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [2:0] mode;
  logic [7:0] din;
  logic       ser_in_lsb;
  logic       ser_in_msb;
  logic       start;
  logic [3:0] count;
  logic [7:0] dout;
  logic       ser_out_msb;
  logic       ser_out_lsb;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  universal_shift_register #(.WIDTH(8), .CNT_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .din         (din),
    .ser_in_lsb  (ser_in_lsb),
    .ser_in_msb  (ser_in_msb),
    .start       (start),
    .count       (count),
    .dout        (dout),
    .ser_out_msb (ser_out_msb),
    .ser_out_lsb (ser_out_lsb),
    .busy        (busy),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [7:0] d, input logic b, input logic dn);
    check({tag, ".dout"}, 32'(dout), 32'(d));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(dn));
  endtask

  task automatic do_load(input logic [7:0] v);
    enable = 1'b1;
    mode   = 3'd1;
    din    = v;
    tick();
    enable = 1'b0;
    mode   = 3'd0;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; mode = 3'd0; din = 8'h00;
    ser_in_lsb = 1'b0; ser_in_msb = 1'b0; start = 1'b0; count = 4'd0;
    #2 reset = 1'b1;
    #1 check_state("reset_init", 8'h00, 1'b0, 1'b0);
    tick();
    @(negedge clock) reset = 1'b0;
    tick();
    check_state("after_release", 8'h00, 1'b0, 1'b0);

    // single-step operations
    do_load(8'hA5);
    check("load_a5", 32'(dout), 32'hA5);
    check("ser_out_msb", 32'(ser_out_msb), 32'd1);
    check("ser_out_lsb", 32'(ser_out_lsb), 32'd1);
    enable = 1'b1; mode = 3'd2; ser_in_lsb = 1'b1;
    tick();
    check("shl_lsb1", 32'(dout), 32'h4B);
    check("ser_out_msb_4b", 32'(ser_out_msb), 32'd0);
    do_load(8'hA5);
    enable = 1'b1; mode = 3'd3; ser_in_msb = 1'b0;
    tick();
    check("shr_msb0", 32'(dout), 32'h52);
    enable = 1'b0; mode = 3'd2;
    tick();
    check("hold_no_enable", 32'(dout), 32'h52);
    enable = 1'b1; mode = 3'd6;
    tick();
    check("hold_code6", 32'(dout), 32'h52);
    enable = 1'b0;

    // ROR burst of 3 from 0xA5
    do_load(8'hA5);
    start = 1'b1; mode = 3'd5; count = 4'd3;
    tick();
    start = 1'b0; mode = 3'd0; count = 4'd0;
    check_state("ror_start", 8'hA5, 1'b1, 1'b0);
    tick();
    check_state("ror_1", 8'hD2, 1'b1, 1'b0);
    tick();
    check_state("ror_2", 8'h69, 1'b1, 1'b0);
    tick();
    check_state("ror_3", 8'hB4, 1'b0, 1'b1);
    tick();
    check_state("ror_after", 8'hB4, 1'b0, 1'b0);

    // SHL burst of 8 streaming ones, with distractions on enable/mode/din
    do_load(8'h00);
    ser_in_lsb = 1'b1;
    start = 1'b1; mode = 3'd2; count = 4'd8;
    tick();
    start = 1'b0;
    check_state("shl8_start", 8'h00, 1'b1, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      enable = k[0];
      mode   = (k[0]) ? 3'd1 : 3'd5;
      din    = 8'h3C ^ 8'(k);
      start  = (k == 3);
      count  = 4'd2;
      tick();
      check_state($sformatf("shl8_step%0d", k), 8'((1 << k) - 1), 1'b1, 1'b0);
    end
    tick();
    enable = 1'b0; mode = 3'd0; start = 1'b0; count = 4'd0;
    check_state("shl8_done", 8'hFF, 1'b0, 1'b1);

    // start with count=0: rejected, single done pulse
    start = 1'b1; mode = 3'd4; count = 4'd0;
    tick();
    start = 1'b0;
    check_state("cnt0_req", 8'hFF, 1'b0, 1'b1);
    tick();
    check_state("cnt0_after", 8'hFF, 1'b0, 1'b0);

    // start+enable with load mode: no load, done pulse
    start = 1'b1; enable = 1'b1; mode = 3'd1; count = 4'd5; din = 8'h3C;
    tick();
    start = 1'b0; enable = 1'b0;
    check_state("start_load", 8'hFF, 1'b0, 1'b1);
    tick();
    check("start_load_after.done", 32'(done), 32'd0);

    // start+enable with SHR: burst taken, enable ignored
    start = 1'b1; enable = 1'b1; mode = 3'd3; count = 4'd1; ser_in_msb = 1'b0;
    tick();
    start = 1'b0; enable = 1'b0;
    check_state("start_shr", 8'hFF, 1'b1, 1'b0);
    tick();
    check_state("start_shr_done", 8'h7F, 1'b0, 1'b1);

    // async reset during a ROL burst of 5
    do_load(8'hFF);
    start = 1'b1; mode = 3'd4; count = 4'd5;
    tick();
    start = 1'b0;
    tick();
    check_state("rol5_mid", 8'hFF, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 check_state("async_reset", 8'h00, 1'b0, 1'b0);
    tick();
    check_state("reset_held", 8'h00, 1'b0, 1'b0);
    @(negedge clock) reset = 1'b0;
    tick();
    check_state("post_reset", 8'h00, 1'b0, 1'b0);
    tick();
    check_state("post_reset2", 8'h00, 1'b0, 1'b0);

    // fresh single-step burst after reset
    do_load(8'h81);
    start = 1'b1; mode = 3'd4; count = 4'd1;
    tick();
    start = 1'b0;
    check_state("rol1_start", 8'h81, 1'b1, 1'b0);
    tick();
    check_state("rol1_done", 8'h03, 1'b0, 1'b1);
    tick();
    check("rol1_after.done", 32'(done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
